// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: FSM encoding, $zero, cycle defaults.
// Optional STALL_STATS_EN in the top level adds a saturating stall-cycle counter.
package pipeline_stall_ctrl_pkg;

   typedef enum logic {
      MdIdle = 1'b0,
      MdBusy = 1'b1
   } md_state_e;

   localparam logic [4:0] RegZero = 5'd0;

   localparam int unsigned MultCyclesDef = 5;
   localparam int unsigned DivCyclesDef  = 10;
   localparam int unsigned CntWDef       = 4;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy tracker: IDLE/BUSY FSM with a down-counter loaded on start.
// A start seen while BUSY is ignored so an in-flight operation is never extended.
module md_busy_timer
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MultCyclesDef,
   parameter int unsigned DIV_CYCLES  = DivCyclesDef,
   parameter int unsigned CNT_W       = CntWDef
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MdIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         MdIdle: begin
            if (start) begin
               state_d = MdBusy;
               cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end
         end
         MdBusy: begin
            // Last busy cycle when the count reaches 1; <= also guards a zero load.
            if (cnt_q <= CNT_W'(1)) begin
               state_d = MdIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   assign busy = (state_q == MdBusy);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ID-stage hazard controller: load-use and HI/LO-busy stalls drive PC/IF-ID enables and ID/EX flush.
// Define STALL_STATS_EN to add the saturating stall_cycles output.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MultCyclesDef,
   parameter int unsigned DIV_CYCLES  = DivCyclesDef,
   parameter int unsigned CNT_W       = CntWDef
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_is_md,
   input  logic        ex_load,
   input  logic [4:0]  ex_wa,
   input  logic        ex_md_start,
   input  logic        ex_md_div,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_ex_flush,
   output logic        stall,
   output logic        md_busy
`ifdef STALL_STATS_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   logic load_use;
   logic md_stall;
   logic stall_raw;

   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_busy_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (ex_md_start),
      .is_div (ex_md_div),
      .busy   (md_busy)
   );

   always_comb begin
      load_use  = ex_load && (ex_wa != RegZero) &&
                  ((id_use_rs && (id_rs == ex_wa)) || (id_use_rt && (id_rt == ex_wa)));
      md_stall  = id_is_md && (md_busy || ex_md_start);
      stall_raw = load_use || md_stall;
   end

   // Reset forces the pipeline to free-run regardless of the hazard inputs.
   assign stall       = stall_raw && !reset;
   assign pc_en       = !stall;
   assign if_id_en    = !stall;
   assign id_ex_flush = stall;

`ifdef STALL_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_pipeline_stall_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_wa;
   logic        id_use_rs, id_use_rt, id_is_md, ex_load, ex_md_start, ex_md_div;
   logic        pc_en, if_id_en, id_ex_flush, stall, md_busy;
`ifdef STALL_STATS_EN
   logic [31:0] stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        stall;
      logic        busy;
      logic        chk_stats;
      logic [31:0] stats;
      string       name;
   } exp_t;

   exp_t sb[$];

   pipeline_stall_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_is_md    (id_is_md),
      .ex_load     (ex_load),
      .ex_wa       (ex_wa),
      .ex_md_start (ex_md_start),
      .ex_md_div   (ex_md_div),
      .pc_en       (pc_en),
      .if_id_en    (if_id_en),
      .id_ex_flush (id_ex_flush),
      .stall       (stall),
      .md_busy     (md_busy)
`ifdef STALL_STATS_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle; sample mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.name, ".stall"}, 32'(stall), 32'(e.stall));
         chk({e.name, ".pc_en"}, 32'(pc_en), 32'(!e.stall));
         chk({e.name, ".if_id_en"}, 32'(if_id_en), 32'(!e.stall));
         chk({e.name, ".flush"}, 32'(id_ex_flush), 32'(e.stall));
         chk({e.name, ".md_busy"}, 32'(md_busy), 32'(e.busy));
`ifdef STALL_STATS_EN
         if (e.chk_stats) chk({e.name, ".stall_cycles"}, stall_cycles, e.stats);
`endif
      end
   end

   task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic ismd, input logic eload,
                       input logic [4:0] ewa, input logic mst, input logic mdiv,
                       input logic es, input logic eb, input logic cs,
                       input logic [31:0] est, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset       = rst;
      id_rs       = rs;
      id_rt       = rt;
      id_use_rs   = urs;
      id_use_rt   = urt;
      id_is_md    = ismd;
      ex_load     = eload;
      ex_wa       = ewa;
      ex_md_start = mst;
      ex_md_div   = mdiv;
      e.stall     = es;
      e.busy      = eb;
      e.chk_stats = cs;
      e.stats     = est;
      e.name      = nm;
      sb.push_back(e);
   endtask

   initial begin
      reset = 1'b1;
      id_rs = '0; id_rt = '0; ex_wa = '0;
      id_use_rs = 0; id_use_rt = 0; id_is_md = 0; ex_load = 0; ex_md_start = 0; ex_md_div = 0;

      //   rst rs     rt     urs urt md ld ewa    mst div  stl bsy cs stats
      step(1, 5'd8,  5'd0,  1, 0, 1, 1, 5'd8,  1, 0,   0, 0, 1, 0, "reset_masks");
      step(0, 5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 0,   0, 0, 1, 0, "idle");
      step(0, 5'd8,  5'd0,  1, 0, 0, 1, 5'd8,  0, 0,   1, 0, 0, 0, "lu_rs");
      step(0, 5'd8,  5'd0,  1, 0, 0, 0, 5'd8,  0, 0,   0, 0, 0, 0, "no_load");
      step(0, 5'd3,  5'd9,  1, 1, 0, 1, 5'd9,  0, 0,   1, 0, 0, 0, "lu_rt");
      step(0, 5'd0,  5'd0,  1, 1, 0, 1, 5'd0,  0, 0,   0, 0, 0, 0, "lu_zero");
      step(0, 5'd8,  5'd0,  0, 0, 0, 1, 5'd8,  0, 0,   0, 0, 0, 0, "lu_unused");
      step(0, 5'd1,  5'd17, 0, 1, 0, 1, 5'd17, 0, 0,   1, 0, 0, 0, "lu_rt2");

      // mult with mfhi held in ID: start cycle + 5 busy cycles stall
      step(0, 5'd0,  5'd0,  0, 0, 1, 0, 5'd0,  1, 0,   1, 0, 0, 0, "mult_start");
      for (int i = 1; i <= 5; i++) begin
         if (i == 3)
            step(0, 5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0, 0, 1, 1, 0, 0, "mult_busy_lu");
         else
            step(0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, 1, 1, 0, 0, "mult_busy");
      end
      step(0, 5'd0,  5'd0,  0, 0, 1, 0, 5'd0,  0, 0,   0, 0, 1, 9, "mult_done");

      // div with a spurious start at busy cycle 3 must not extend
      step(0, 5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  1, 1,   0, 0, 0, 0, "div_start");
      for (int i = 1; i <= 10; i++) begin
         step(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, logic'(i == 3), 0, 0, 1, 0, 0, "div_busy");
      end
      step(0, 5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 0,   0, 0, 1, 9, "div_done");

      // reset at busy cycle 4 aborts immediately
      step(0, 5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  1, 0,   0, 0, 0, 0, "abort_start");
      for (int i = 1; i <= 3; i++) begin
         step(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, "abort_busy");
      end
      step(1, 5'd8,  5'd0,  1, 0, 1, 1, 5'd8,  0, 0,   0, 0, 1, 0, "abort_reset");
      step(0, 5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  1, 0,   0, 0, 1, 0, "fresh_start");
      for (int i = 1; i <= 5; i++) begin
         step(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, "fresh_busy");
      end
      step(0, 5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 0,   0, 0, 0, 0, "fresh_done");

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
